scan_code_sequencer: RTL
========================

Name: scan_code_sequencer

Overview:
- Upstream stage of the 4-to-16 one-hot decoder: generates the 4-bit channel code the decoder consumes.
- Walks the enabled channels of a 16-bit mask in ascending order and holds each code for a programmable dwell time.
- Runs one-shot or continuous, with start/stop control and step/frame status pulses for LED/row scan and channel-select sequencing.

Parameters:
- DWELL_W, 8, width of the dwell count; channel hold = dwell+1 cycles.
- IDLE_CODE, 4'h0, value driven on code while not scanning.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start  input  1  begin a scan; sampled only in IDLE.
- stop  input  1  synchronous abort; wins over start.
- continuous  input  1  1 = wrap and rescan forever; 0 = one frame then IDLE. Latched at start.
- dwell  input  DWELL_W  hold count, latched at start and at each wrap.
- ch_mask  input  16  channel enable mask; bit i enables code i. Latched at start and at each wrap.
- code  output  4  channel code to the decoder.
- code_valid  output  1  code is an active channel.
- step_pulse  output  1  one cycle, first cycle of each new code.
- frame_done  output  1  one cycle, end of each frame.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state IDLE.
  - code=IDLE_CODE; code_valid, step_pulse, frame_done, busy all 0.
  - Latched mask, dwell and continuous = 0; dwell counter = 0.
- All outputs registered. Next-channel search is a combinational priority pick: lowest set mask bit above the current code.
- States: IDLE, DWELL, GAP (GAP only with SCAN_GAP_EN).
- IDLE:
  - start=1 and stop=0 → latch ch_mask/dwell/continuous.
  - Latched mask nonzero → next cycle: DWELL, code=lowest enabled channel, code_valid=1, step_pulse=1, counter=dwell, busy=1.
  - Latched mask zero → stay IDLE, frame_done=1 for one cycle, busy stays 0.
  - start and stop together → ignored.
- DWELL:
  - counter!=0 → decrement; code held.
  - counter==0 and a higher enabled channel exists → next cycle: that code, step_pulse=1, counter reloaded with latched dwell.
  - counter==0 and current code is the last enabled channel → frame end; frame_done=1 in the next cycle.
    - One-shot: next cycle IDLE, code=IDLE_CODE, code_valid=0, busy=0.
    - Continuous: re-latch ch_mask and dwell, wrap to the lowest channel of the NEW mask with step_pulse=1. New mask zero → IDLE with frame_done=1.
- stop=1 in any non-IDLE state → next cycle IDLE, code_valid=0, code=IDLE_CODE, busy=0. No frame_done or step_pulse that cycle.
- start while busy → ignored.
- ch_mask/dwell changes mid-frame → no effect until the next wrap or start.
- Code 15 as last channel: no overflow; end-of-frame logic applies.
- A single enabled channel in continuous mode → step_pulse every dwell+1 cycles; frame_done coincides with each step_pulse after the first.

Optional Feature:
- SCAN_GAP_EN defined: break-before-make.
  - Each channel change (including a continuous wrap) passes through GAP for exactly one cycle: code_valid=0, code holds the previous value, step_pulse=0.
  - At a wrap, frame_done is asserted in the GAP cycle, not with the new code.
  - The new code then appears with step_pulse=1.
  - One-shot frame end and stop go straight to IDLE with no GAP.
- SCAN_GAP_EN undefined: GAP state absent; codes change back-to-back.

Test Plan:
- ch_mask=16'hFFFF, dwell=0, continuous=0, pulse start → codes 0..15 one per cycle, code_valid high 16 cycles, 16 step_pulses; frame_done on cycle 17; busy low from cycle 17.
- ch_mask=16'h8421, dwell=2, one-shot → codes 0,5,10,15, each for 3 cycles; 4 step_pulses; frame_done once, after the 12th valid cycle.
- continuous=1, ch_mask=16'h0003, dwell=1 → sequence 0,0,1,1,0,0,…; frame_done every 4 cycles. Switch ch_mask to 16'h0004 during code 0 → 0,0,1,1 completes, then 2,2,2,2,… (frame_done every 2 cycles).
- ch_mask=0, start → busy never high, code_valid 0, frame_done single pulse one cycle after start.
- Scan 16'hFFFF, dwell=3, assert stop while code=7 → next cycle IDLE, code=IDLE_CODE, no frame_done. start+stop together in IDLE → no activity.
- Assert rst asynchronously mid-dwell, between clock edges → all outputs at reset values before the next clk edge. After release, start resumes from the lowest enabled channel. With SCAN_GAP_EN, repeat test 2 → one code_valid=0 cycle between 0→5, 5→10 and 10→15.

Source files
------------

// File: rtl/scan_code_sequencer.sv
// Purpose: walks enabled channels of a 16-bit mask in ascending order, holding each code dwell+1 cycles.
// Latency: first code appears one cycle after start is sampled; all outputs are registered.
// Backpressure: none; stop aborts to IDLE next cycle. Define SCAN_GAP_EN for a one-cycle break-before-make gap.
module scan_code_sequencer #(
   parameter int         DWELL_W   = 8,
   parameter logic [3:0] IDLE_CODE = 4'h0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               continuous,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [15:0]        ch_mask,
   output logic [3:0]         code,
   output logic               code_valid,
   output logic               step_pulse,
   output logic               frame_done,
   output logic               busy
);

`ifdef SCAN_GAP_EN
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DWELL = 2'd1, S_GAP = 2'd2} state_t;
`else
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_DWELL = 2'd1} state_t;
`endif

   localparam logic [DWELL_W-1:0] CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

   state_t             state, state_n;
   logic [3:0]         code_n;
   logic               valid_n, step_n, frame_n;
   logic [DWELL_W-1:0] cnt, cnt_n;
   logic [15:0]        lat_mask, lat_mask_n;
   logic [DWELL_W-1:0] lat_dwell, lat_dwell_n;
   logic               lat_cont, lat_cont_n;
   logic [4:0]         above_pick;   // {found, code} of next enabled channel above current
   logic [4:0]         new_pick;     // {found, code} of lowest channel in the incoming mask
`ifdef SCAN_GAP_EN
   logic [3:0]         pend, pend_n; // code to present once the gap cycle ends
`endif

   // Priority pick: index of the lowest set bit, MSB of result flags "any set".
   function automatic logic [4:0] lowest_set(input logic [15:0] m);
      logic [4:0] r;
      r = 5'b0;
      for (int i = 15; i >= 0; i--) begin
         if (m[i]) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

   assign above_pick = lowest_set(lat_mask & (16'hFFFE << code));
   assign new_pick   = lowest_set(ch_mask);

   // Next-state and next-output decode; registered below so every output is a flop.
   always_comb begin
      state_n     = state;
      code_n      = code;
      valid_n     = code_valid;
      step_n      = 1'b0;
      frame_n     = 1'b0;
      cnt_n       = cnt;
      lat_mask_n  = lat_mask;
      lat_dwell_n = lat_dwell;
      lat_cont_n  = lat_cont;
`ifdef SCAN_GAP_EN
      pend_n      = pend;
`endif
      case (state)
         S_IDLE: begin
            code_n  = IDLE_CODE;
            valid_n = 1'b0;
            if (start && !stop) begin
               lat_mask_n  = ch_mask;
               lat_dwell_n = dwell;
               lat_cont_n  = continuous;
               if (new_pick[4]) begin
                  state_n = S_DWELL;
                  code_n  = new_pick[3:0];
                  valid_n = 1'b1;
                  step_n  = 1'b1;
                  cnt_n   = dwell;
               end else begin
                  frame_n = 1'b1;   // empty frame completes immediately
               end
            end
         end
         S_DWELL: begin
            if (stop) begin
               state_n = S_IDLE;
               code_n  = IDLE_CODE;
               valid_n = 1'b0;
            end else if (cnt != '0) begin
               cnt_n = cnt - CNT_ONE;
            end else if (above_pick[4]) begin
`ifdef SCAN_GAP_EN
               state_n = S_GAP;
               valid_n = 1'b0;
               pend_n  = above_pick[3:0];
`else
               code_n  = above_pick[3:0];
               step_n  = 1'b1;
               cnt_n   = lat_dwell;
`endif
            end else if (!lat_cont) begin
               state_n = S_IDLE;
               code_n  = IDLE_CODE;
               valid_n = 1'b0;
               frame_n = 1'b1;
            end else begin
               // Wrap: pick up mask and dwell changes made during the frame.
               lat_mask_n  = ch_mask;
               lat_dwell_n = dwell;
               frame_n     = 1'b1;
               if (new_pick[4]) begin
`ifdef SCAN_GAP_EN
                  state_n = S_GAP;
                  valid_n = 1'b0;
                  pend_n  = new_pick[3:0];
`else
                  code_n  = new_pick[3:0];
                  step_n  = 1'b1;
                  cnt_n   = dwell;
`endif
               end else begin
                  state_n = S_IDLE;
                  code_n  = IDLE_CODE;
                  valid_n = 1'b0;
               end
            end
         end
`ifdef SCAN_GAP_EN
         S_GAP: begin
            if (stop) begin
               state_n = S_IDLE;
               code_n  = IDLE_CODE;
               valid_n = 1'b0;
            end else begin
               state_n = S_DWELL;
               code_n  = pend;
               valid_n = 1'b1;
               step_n  = 1'b1;
               cnt_n   = lat_dwell;
            end
         end
`endif
         default: begin
            state_n = S_IDLE;
            code_n  = IDLE_CODE;
            valid_n = 1'b0;
         end
      endcase
   end

   // State, counter, latched configuration and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         code       <= IDLE_CODE;
         code_valid <= 1'b0;
         step_pulse <= 1'b0;
         frame_done <= 1'b0;
         busy       <= 1'b0;
         cnt        <= '0;
         lat_mask   <= '0;
         lat_dwell  <= '0;
         lat_cont   <= 1'b0;
      end else begin
         state      <= state_n;
         code       <= code_n;
         code_valid <= valid_n;
         step_pulse <= step_n;
         frame_done <= frame_n;
         busy       <= (state_n != S_IDLE);
         cnt        <= cnt_n;
         lat_mask   <= lat_mask_n;
         lat_dwell  <= lat_dwell_n;
         lat_cont   <= lat_cont_n;
      end
   end

`ifdef SCAN_GAP_EN
   // Holds the pending channel across the gap cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pend <= 4'h0;
      else     pend <= pend_n;
   end
`endif

endmodule
